fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register. It holds the PC, addresses the
//  instruction memory and registers {instr, pc, pc+4, valid} for the decode stage, whose
//  main decoder consumes instr_o[6:0]. It handles redirects from branch/jump resolution
//  and load-use stalls, and halts the core on an unsupported opcode reaching decode.
// PARAMETERS
//  ADDR_WIDTH   32            PC / instruction-address width
//  DATA_WIDTH   32            instruction width
//  RESET_PC     32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous, active-high reset
//  stall_i        in   1           hold PC and IF/ID (load-use hazard)
//  flush_i        in   1           replace IF/ID contents with a bubble
//  pc_src_i       in   1           redirect: (Branch & Zero) | J from execute
//  pc_target_i    in   ADDR_WIDTH  redirect target; bits[1:0] are ignored and forced 0
//  imem_addr_o    out  ADDR_WIDTH  = PC register (combinational, asynchronous-read ROM)
//  imem_rdata_i   in   DATA_WIDTH  instruction at imem_addr_o, same cycle
//  instr_o        out  DATA_WIDTH  IF/ID instruction
//  pc_o           out  ADDR_WIDTH  IF/ID PC of instr_o
//  pc_plus4_o     out  ADDR_WIDTH  IF/ID pc_o + 4
//  valid_o        out  1           instr_o is a real instruction (0 = bubble)
//  halted_o       out  1           core halted on an unsupported opcode (sticky)
//  fetch_count_o  out  32          number of valid instructions captured into IF/ID
// BEHAVIOUR
//  Reset (sync, highest priority): PC=RESET_PC, instr_o=NOP (32'h0000_0013), pc_o=0,
//   pc_plus4_o=0, valid_o=0, halted_o=0, fetch_count_o=0, state=RUN.
//  FSM: RUN -> HALT when valid_o & instr_o[6:0] not in {0000011,0100011,0110011,
//   1100011,1101111} & !stall_i & !flush_i & !pc_src_i (the instruction would advance).
//   HALT -> RUN only via rst. In HALT: PC frozen, IF/ID forced to bubble, halted_o=1,
//   and all inputs except rst are ignored.
//  PC update in RUN, by priority: pc_src_i -> {pc_target_i[ADDR_WIDTH-1:2],2'b00};
//   else stall_i -> hold; else PC+4. Wrap-around is modulo 2^ADDR_WIDTH.
//   A redirect wins over a stall because the stalled instruction is on the wrong path.
//  IF/ID update in RUN, by priority: (flush_i | pc_src_i) -> bubble (NOP, valid 0,
//   pc_o/pc_plus4_o hold); else stall_i -> hold all fields; else capture imem_rdata_i,
//   PC and PC+4 with valid_o=1.
//  Latency: an instruction fetched in cycle n appears on instr_o in cycle n+1. The
//   first valid instruction is visible one cycle after rst deasserts.
//  fetch_count_o increments by 1 on every capture with valid=1. It wraps at 2^32 and
//   holds under stall, flush and HALT.
//  Simultaneous stall_i & flush_i (no redirect): PC holds, and IF/ID becomes a bubble.
//  Reset mid-operation: all state, including halted_o, returns to reset values next edge.
//  Outputs are registered except imem_addr_o; no combinational path input->output.
// STRUCTURE
//  Shared package riscv_pkg: opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH,
//   OP_JAL), NOP_INSTR, fetch_state_t enum {RUN, HALT}, and function is_supported_op().
//   The main decoder reuses the same opcode constants.
//  Sub-module pc_register: holds PC with rst/stall/redirect priority. The IF/ID register,
//   FSM and counter live in fetch_stage.
// TESTING
//  Reset then 4 free cycles with ROM = addi x1..x4 -> imem_addr 0,4,8,12; instr_o lags
//   by 1 cycle; valid_o=1 from cycle 1; fetch_count_o=3 after the 4th edge.
//  pc_src_i=1, target=0x40 at PC=0x8 -> next PC=0x40; IF/ID = NOP, valid 0; the
//   next capture has pc_o=0x40, pc_plus4_o=0x44.
//  stall_i for 2 cycles at PC=0xC -> PC and IF/ID hold; fetch_count_o holds; then
//   resumes at 0x10.
//  stall_i & pc_src_i together with target=0x23 -> PC=0x20 (bits[1:0] cleared); IF/ID bubble.
//  ROM word 0x0000_0000 at 0x10 reaches decode with no stall -> halted_o=1 next
//   edge; PC frozen at 0x14; valid_o=0; only rst clears it.
//  Same illegal word in a branch shadow (pc_src_i=1 that cycle) -> no halt; redirect taken.
//  PC=0xFFFF_FFFC free-run -> next PC=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
// Contents:
//   - Opcode constants for the subset this core executes.
//     The main decoder uses these same constants.
//   - The NOP encoding (addi x0, x0, 0), which is used as the pipeline bubble.
//   - The fetch FSM state type.
//   - is_supported_op(): returns 1 for opcodes the core can execute.
package riscv_pkg;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_supported_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_JAL: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register.
// Ports:
//   clk, rst    clock; synchronous active-high reset (loads RESET_PC)
//   freeze_i    hold the PC unconditionally (halted core, or halt being entered)
//   redirect_i  load target_i with bits[1:0] cleared
//   stall_i     hold the PC when no redirect is pending
//   target_i    redirect target
//   pc_o        current PC
// Priority: rst > freeze > redirect > stall > PC+4.
// A redirect beats a stall because the stalled instruction is on the wrong path.
module pc_register #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze_i,
    input  logic                  redirect_i,
    input  logic                  stall_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o <= RESET_PC;
        end else if (freeze_i) begin
            pc_o <= pc_o;
        end else if (redirect_i) begin
            pc_o <= {target_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_o <= pc_o + ADDR_WIDTH'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall_i            load-use stall: hold the PC and IF/ID
//   flush_i            turn the IF/ID contents into a bubble
//   pc_src_i           redirect request from execute
//   pc_target_i        redirect target (bits[1:0] are ignored)
//   imem_addr_o        instruction address, taken directly from the PC
//   imem_rdata_i       instruction returned by the asynchronous ROM
//   instr_o            IF/ID instruction
//   pc_o, pc_plus4_o   IF/ID PC and PC+4
//   valid_o            IF/ID holds a real instruction (0 = bubble)
//   halted_o           sticky halt caused by an unsupported opcode
//   fetch_count_o      number of valid instructions captured
//
// State | Meaning
// RUN   | normal fetching
// HALT  | unsupported opcode reached decode. The PC is frozen, IF/ID holds a
//       | bubble, and only rst leaves this state.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  pc_src_i,
    input  logic [ADDR_WIDTH-1:0] pc_target_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o,
    output logic                  halted_o,
    output logic [31:0]           fetch_count_o
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halt_req;
    logic                  freeze;

    // A halt is raised only when the bad instruction would actually advance.
    // If it is stalled, flushed or shadowed by a redirect, it never executes.
    assign halt_req = (state == RUN) && valid_o && !is_supported_op(instr_o[6:0])
                      && !stall_i && !flush_i && !pc_src_i;

    // The PC also freezes on the halt-entry edge, so that it stays on the
    // instruction after the offending one.
    assign freeze = (state == HALT) || halt_req;

    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .freeze_i   (freeze),
        .redirect_i (pc_src_i),
        .stall_i    (stall_i),
        .target_i   (pc_target_i),
        .pc_o       (pc)
    );

    assign imem_addr_o = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            instr_o       <= DATA_WIDTH'(NOP_INSTR);
            pc_o          <= '0;
            pc_plus4_o    <= '0;
            valid_o       <= 1'b0;
            halted_o      <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        halted_o <= 1'b1;
                        instr_o  <= DATA_WIDTH'(NOP_INSTR);
                        valid_o  <= 1'b0;
                    end else if (flush_i || pc_src_i) begin
                        // Bubble: pc_o and pc_plus4_o keep their previous values.
                        instr_o <= DATA_WIDTH'(NOP_INSTR);
                        valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        instr_o       <= imem_rdata_i;
                        pc_o          <= pc;
                        pc_plus4_o    <= pc + ADDR_WIDTH'(4);
                        valid_o       <= 1'b1;
                        fetch_count_o <= fetch_count_o + 32'd1;
                    end
                end
                HALT: begin
                    instr_o  <= DATA_WIDTH'(NOP_INSTR);
                    valid_o  <= 1'b0;
                    halted_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        pc_src_i = 1'b0;
    logic [31:0] pc_target_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    logic [31:0] rom [0:127];
    logic [6:0]  okops [0:4] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b1101111};

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pco, m_pc4, m_cnt;
    logic        m_valid, m_halted;

    fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .pc_src_i      (pc_src_i),
        .pc_target_i   (pc_target_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o),
        .halted_o      (halted_o),
        .fetch_count_o (fetch_count_o)
    );

    always #5 clk = ~clk;

    // Small ROM at low addresses. Every other address returns a load word.
    assign imem_rdata_i = (imem_addr_o < 32'd512) ? rom[imem_addr_o[8:2]]
                                                  : {imem_addr_o[31:7], 7'b0000011};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'd512) return rom[a[8:2]];
        return {a[31:7], 7'b0000011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic p, input logic [31:0] t);
        logic [31:0] fetched;
        fetched = rom_word(m_pc);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h13; m_pco = 0; m_pc4 = 0;
            m_valid = 0; m_halted = 0; m_cnt = 0;
        end else if (!m_halted) begin
            if (m_valid && !(m_instr[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011,
                                                  7'b1100011, 7'b1101111})
                && !s && !f && !p) begin
                m_halted = 1; m_instr = 32'h13; m_valid = 0;
            end else begin
                if (f || p) begin
                    m_instr = 32'h13; m_valid = 0;
                end else if (!s) begin
                    m_instr = fetched; m_pco = m_pc; m_pc4 = m_pc + 4;
                    m_valid = 1; m_cnt = m_cnt + 1;
                end
                if (p)       m_pc = {t[31:2], 2'b00};
                else if (!s) m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f,
                        input logic p, input logic [31:0] t);
        rst = r; stall_i = s; flush_i = f; pc_src_i = p; pc_target_i = t;
        model_edge(r, s, f, p, t);
        @(posedge clk);
        #1;
        chk("addr",   imem_addr_o,   m_pc);
        chk("instr",  instr_o,       m_instr);
        chk("pc",     pc_o,          m_pco);
        chk("pc4",    pc_plus4_o,    m_pc4);
        chk("valid",  32'(valid_o),  32'(m_valid));
        chk("halted", 32'(halted_o), 32'(m_halted));
        chk("count",  fetch_count_o, m_cnt);
    endtask

    task automatic free();
        step(0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int halt_cycles;
        m_pc = 0; m_instr = 32'h13; m_pco = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            logic [24:0] hi;
            hi = 25'(i * 3 + 1);
            rom[i] = {hi, okops[i % 5]};
        end
        rom[4] = 32'h0000_0000;

        // reset state
        step(1, 0, 0, 0, 0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_count", fetch_count_o, 32'h0);

        // free running and first-capture latency
        free();
        chk("first_valid", 32'(valid_o), 32'h1);
        chk("first_instr", instr_o, rom[0]);
        free(); free();
        chk("cnt3", fetch_count_o, 32'd3);
        chk("addr_c", imem_addr_o, 32'hC);

        // two-cycle stall at 0xC
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("stall_pc", imem_addr_o, 32'hC);
        chk("stall_cnt", fetch_count_o, 32'd3);
        free();
        chk("resume_pc", imem_addr_o, 32'h10);
        free();
        chk("illegal_in_id", instr_o, 32'h0);

        // illegal word in a branch shadow: no halt, redirect is taken
        step(0, 0, 0, 1, 32'h40);
        chk("shadow_nohalt", 32'(halted_o), 32'h0);
        chk("redir_pc", imem_addr_o, 32'h40);
        chk("redir_bubble", 32'(valid_o), 32'h0);
        free();
        chk("redir_pco", pc_o, 32'h40);
        chk("redir_pc4", pc_plus4_o, 32'h44);

        // redirect beats stall; low target bits are cleared
        step(0, 1, 0, 1, 32'h23);
        chk("stall_redir_pc", imem_addr_o, 32'h20);
        chk("stall_redir_bub", 32'(valid_o), 32'h0);

        // stall together with flush: PC holds and IF/ID becomes a bubble
        free();
        step(0, 1, 1, 0, 0);
        chk("stflush_pc", imem_addr_o, 32'h24);
        chk("stflush_bub", 32'(valid_o), 32'h0);

        // illegal word reaches decode: halt
        step(0, 0, 0, 1, 32'h10);
        free();
        free();
        chk("halt_set", 32'(halted_o), 32'h1);
        chk("halt_pc", imem_addr_o, 32'h14);
        chk("halt_valid", 32'(valid_o), 32'h0);
        for (int i = 0; i < 3; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        chk("halt_frozen", imem_addr_o, 32'h14);
        step(1, 0, 0, 0, 0);
        chk("halt_cleared", 32'(halted_o), 32'h0);

        // PC wrap-around
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        free();
        chk("wrap_pc", imem_addr_o, 32'h0);
        chk("wrap_pco", pc_o, 32'hFFFF_FFFC);

        // randomized phase: a fresh ROM with roughly 1 illegal word in 6
        rst = 1'b1;
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            int k;
            w = $urandom;
            k = int'($urandom_range(0, 5));
            w[6:0] = (k == 5) ? 7'b0010011 : okops[k];
            rom[i] = w;
        end
        step(1, 0, 0, 0, 0);
        halt_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            logic r, s, f, p;
            logic [31:0] t;
            r = (halt_cycles > 3) || ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 511));
            step(r, s, f, p, t);
            halt_cycles = m_halted ? halt_cycles + 1 : 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
